// File: rtl/pad_vector_bist_if.sv
// Pad-level bus between the BIST engine and its controller: run control,
// golden signature, DUT stimulus/response and status.
interface pad_vector_bist_if #(
  parameter int unsigned VEC_W = 10,
  parameter int unsigned RSP_W = 7
);
  logic             start_i;
  logic             abort_i;
  logic             mode_i;
  logic [RSP_W-1:0] expected_i;
  logic [RSP_W-1:0] rsp_i;
  logic [VEC_W-1:0] vec_o;
  logic             busy_o;
  logic             done_o;
  logic [RSP_W-1:0] sig_o;
  logic             pass_o;
  logic [15:0]      vec_cnt_o;

  modport master (
    output start_i, abort_i, mode_i, expected_i, rsp_i,
    input  vec_o, busy_o, done_o, sig_o, pass_o, vec_cnt_o
  );

  modport slave (
    input  start_i, abort_i, mode_i, expected_i, rsp_i,
    output vec_o, busy_o, done_o, sig_o, pass_o, vec_cnt_o
  );
endinterface

// File: rtl/pad_vector_bist.sv
// Stimulus/response BIST for a combinational pad netlist: LFSR or counter
// vectors out, MISR-compacted responses in, signature checked against golden.
module pad_vector_bist #(
  parameter int unsigned      VEC_W   = 10,
  parameter int unsigned      RSP_W   = 7,
  parameter int unsigned      NUM_VEC = 1024,
  parameter logic [VEC_W-1:0] SEED    = VEC_W'(1)
) (
  input logic              clk,
  input logic              rst,
  pad_vector_bist_if.slave bus
);

  localparam int unsigned      CNT_W    = 16;
  // An all-zero seed would lock the LFSR, so it falls back to 1.
  localparam logic [VEC_W-1:0] SEED_EFF = (SEED == '0) ? VEC_W'(1) : SEED;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [RSP_W-1:0]   sig_q, sig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [VEC_W-1:0]   lfsr_nxt_c;
  logic [RSP_W-1:0]   misr_nxt_c;

  // x^10+x^7+1 stimulus LFSR and x^7+x^6+1 response MISR
  assign lfsr_nxt_c = {vec_q[VEC_W-2:0], vec_q[9] ^ vec_q[6]};
  assign misr_nxt_c = {sig_q[RSP_W-2:0], sig_q[6] ^ sig_q[5]} ^ bus.rsp_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      sig_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    // Abort wins over everything and leaves sig/count frozen for debug.
    if (bus.abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start_i) begin
            mode_d  = bus.mode_i;
            vec_d   = bus.mode_i ? '0 : SEED_EFF;
            sig_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          sig_d = misr_nxt_c;
          cnt_d = cnt_q + CNT_W'(1);
          vec_d = mode_q ? (vec_q + VEC_W'(1)) : lfsr_nxt_c;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.vec_o     = vec_q;
  assign bus.sig_o     = sig_q;
  assign bus.vec_cnt_o = cnt_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.pass_o    = (state_q == DONE) && (sig_q == bus.expected_i);

endmodule
